// File: rtl/cpu_jtag_monitor_mem.sv
// JTAG debug monitor RAM for a soft CPU.
// The RAM is a single-port array shared by two masters:
//   - a JTAG side driven by single-cycle action pulses from the debug module;
//   - a CPU slave port with waitrequest-based stalling.
// A JTAG pulse seen in IDLE always wins over a concurrent CPU request.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting; accepts JTAG pulses and CPU requests
// J_RD   | JTAG read: RAM addressed at MonAReg
// J_RDW  | JTAG read: RAM data captured into MonDReg, MonAReg advances
// J_WR   | JTAG write: MonDReg written at MonAReg, MonAReg advances
// C_RD   | CPU read: RAM addressed at the CPU address
// C_DONE | CPU read data on readdata, waitrequest released

module cpu_jtag_monitor_mem #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    input  logic [AW-1:0] address,
    input  logic          read,
    input  logic          write,
    input  logic [31:0]   writedata,
    input  logic [3:0]    byteenable,
    input  logic          debugaccess,
    output logic [31:0]   readdata,
    output logic          waitrequest,
    output logic [31:0]   MonDReg,
    output logic [AW-1:0] MonAReg,
    output logic          jtag_busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        J_RD   = 3'd1,
        J_RDW  = 3'd2,
        J_WR   = 3'd3,
        C_RD   = 3'd4,
        C_DONE = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] mon_a_q, mon_a_d;
    logic [31:0]   mon_d_q, mon_d_d;
    logic [31:0]   readdata_q;

    logic [31:0]   mem_q [MEM_WORDS];
    logic [31:0]   ram_rdata_q;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic          cpu_done;

    // jdo bits outside the data/address/read-flag fields carry nothing for this block
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    // State and monitor registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mon_a_q <= '0;
            mon_d_q <= '0;
        end else begin
            state_q <= state_d;
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
        end
    end

    // Next-state, RAM port steering and CPU completion
    always_comb begin
        state_d   = state_q;
        mon_a_d   = mon_a_q;
        mon_d_d   = mon_d_q;
        ram_addr  = mon_a_q;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 4'hF;
        ram_wdata = mon_d_q;
        cpu_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take_action_ocimem_b) begin
                    mon_d_d = jdo[34:3];
                    state_d = J_WR;
                end else if (take_action_ocimem_a) begin
                    mon_a_d = jdo[AW+25:26];
                    if (jdo[17]) begin
                        state_d = J_RD;
                    end
                end else if (take_no_action_ocimem_a) begin
                    state_d = J_RD;
                end else if (write) begin
                    // unprivileged writes complete on the bus but never reach the RAM
                    cpu_done = 1'b1;
                    if (debugaccess) begin
                        ram_we    = 1'b1;
                        ram_addr  = address;
                        ram_be    = byteenable;
                        ram_wdata = writedata;
                    end
                end else if (read) begin
                    state_d = C_RD;
                end
            end
            J_RD: begin
                ram_re  = 1'b1;
                state_d = J_RDW;
            end
            J_RDW: begin
                mon_d_d = ram_rdata_q;
                mon_a_d = mon_a_q + AW'(1);
                state_d = IDLE;
            end
            J_WR: begin
                ram_we  = 1'b1;
                mon_a_d = mon_a_q + AW'(1);
                state_d = IDLE;
            end
            C_RD: begin
                ram_re   = 1'b1;
                ram_addr = address;
                state_d  = C_DONE;
            end
            C_DONE: begin
                cpu_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Synchronous-read RAM with byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) begin
                    mem_q[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
        end
        if (ram_re) begin
            ram_rdata_q <= mem_q[ram_addr];
        end
    end

    // Hold the last CPU read value so readdata stays stable outside C_DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else if (state_q == C_DONE) begin
            readdata_q <= ram_rdata_q;
        end
    end

    assign readdata    = (state_q == C_DONE) ? ram_rdata_q : readdata_q;
    assign waitrequest = (read | write) & ~cpu_done;
    assign jtag_busy   = (state_q == J_RD) || (state_q == J_RDW) || (state_q == J_WR);
    assign MonDReg     = mon_d_q;
    assign MonAReg     = mon_a_q;

endmodule

// File: tb/tb_cpu_jtag_monitor_mem.sv
// Scoreboard bench for the JTAG monitor RAM: drivers update a word-array
// reference model and queue expected responses; a monitor pops and compares
// whenever a JTAG access finishes or a CPU read is released.

module tb_cpu_jtag_monitor_mem;

    localparam int AW = 8;
    localparam int N  = 256;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [37:0]   jdo = '0;
    logic          ta_a = 1'b0;
    logic          ta_b = 1'b0;
    logic          tna = 1'b0;
    logic [AW-1:0] address = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [3:0]    byteenable = '0;
    logic          debugaccess = 1'b0;
    logic [31:0]   readdata;
    logic          waitrequest;
    logic [31:0]   MonDReg;
    logic [AW-1:0] MonAReg;
    logic          jtag_busy;

    cpu_jtag_monitor_mem #(.MEM_WORDS(N), .AW(AW)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tna),
        .address                 (address),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .debugaccess             (debugaccess),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .jtag_busy               (jtag_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [31:0] mdl_mem [N];
    logic [7:0]  mdl_a = 8'h00;
    logic [31:0] mdl_d = 32'h0;

    typedef struct { logic [7:0] a; logic [31:0] d; } jexp_t;
    typedef struct { logic [31:0] d; int stall; } cexp_t;
    jexp_t jq[$];
    cexp_t cq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [37:0] rand_jdo();
        return {6'($urandom), $urandom};
    endfunction

    // monitor: JTAG completion on falling busy, CPU read completion on released wait
    logic busy_prev = 1'b0;
    int   stall_cnt = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_prev = 1'b0;
            stall_cnt = 0;
        end else begin
            if (busy_prev && !jtag_busy) begin
                if (jq.size() == 0) begin
                    timeout("jtag_unexpected_completion");
                end else begin
                    jexp_t e;
                    e = jq.pop_front();
                    check("jtag_MonAReg", 32'(MonAReg), 32'(e.a));
                    check("jtag_MonDReg", MonDReg, e.d);
                end
            end
            busy_prev = jtag_busy;
            if (read && !write) begin
                if (waitrequest) begin
                    stall_cnt++;
                end else if (cq.size() == 0) begin
                    timeout("cpu_unexpected_completion");
                end else begin
                    cexp_t c;
                    c = cq.pop_front();
                    check("cpu_readdata", readdata, c.d);
                    check("cpu_read_stall", 32'(stall_cnt), 32'(c.stall));
                    stall_cnt = 0;
                end
            end else begin
                stall_cnt = 0;
            end
        end
    end

    task automatic pulse_jtag(input logic a, input logic b, input logic n, input logic [37:0] j);
        @(posedge clk); #1;
        jdo = j; ta_a = a; ta_b = b; tna = n;
        @(posedge clk); #1;
        ta_a = 1'b0; ta_b = 1'b0; tna = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!jtag_busy) break;
        end
        if (k == 10) timeout(name);
    endtask

    task automatic jtag_set_addr(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = rand_jdo();
        j[33:26] = a;
        j[17] = rd;
        mdl_a = a;
        if (rd) begin
            mdl_d = mdl_mem[mdl_a];
            mdl_a = mdl_a + 8'd1;
            jq.push_back('{a: mdl_a, d: mdl_d});
        end
        pulse_jtag(1'b1, 1'b0, 1'b0, j);
        wait_idle("jtag_set_addr_done");
    endtask

    task automatic jtag_write(input logic [31:0] d);
        logic [37:0] j;
        j = rand_jdo();
        j[34:3] = d;
        mdl_mem[mdl_a] = d;
        mdl_d = d;
        mdl_a = mdl_a + 8'd1;
        jq.push_back('{a: mdl_a, d: mdl_d});
        pulse_jtag(1'b0, 1'b1, 1'b0, j);
        wait_idle("jtag_write_done");
    endtask

    // inject: fire extra pulses while the read is in flight; they must be ignored
    task automatic jtag_read(input logic inject);
        mdl_d = mdl_mem[mdl_a];
        mdl_a = mdl_a + 8'd1;
        jq.push_back('{a: mdl_a, d: mdl_d});
        pulse_jtag(1'b0, 1'b0, 1'b1, rand_jdo());
        if (inject) begin
            jdo = rand_jdo(); ta_a = 1'b1; ta_b = 1'b1;
            @(posedge clk); #1;
            ta_a = 1'b0; ta_b = 1'b0;
        end
        wait_idle("jtag_read_done");
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                             input logic dbg, input logic also_rd);
        @(posedge clk); #1;
        address = a; writedata = d; byteenable = be; debugaccess = dbg;
        write = 1'b1; read = also_rd;
        @(negedge clk);
        check("cpu_write_waitrequest", 32'(waitrequest), 32'd0);
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        if (dbg) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mdl_mem[a][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    task automatic wait_cpu(input string name);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!waitrequest) break;
        end
        if (k == 20) timeout(name);
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a);
        cq.push_back('{d: mdl_mem[a], stall: 2});
        @(posedge clk); #1;
        address = a; read = 1'b1;
        wait_cpu("cpu_read_done");
        @(negedge clk);
        check("readdata_hold", readdata, mdl_mem[a]);
    endtask

    initial begin
        logic [7:0]  a0;
        logic [31:0] d0;
        logic [37:0] j;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_MonDReg", MonDReg, 32'h0);
        check("reset_MonAReg", 32'(MonAReg), 32'h0);
        check("reset_jtag_busy", 32'(jtag_busy), 32'h0);
        check("reset_waitrequest", 32'(waitrequest), 32'h0);
        check("reset_readdata", readdata, 32'h0);
        #1 reset_n = 1'b1;

        // fill the whole RAM over JTAG; the address wraps back to 0 at the end
        jtag_set_addr(8'h00, 1'b0);
        for (int i = 0; i < N; i++) jtag_write($urandom);
        check("fill_wrap_MonAReg", 32'(MonAReg), 32'h0);

        // JTAG write then read back
        jtag_set_addr(8'h10, 1'b0);
        jtag_write(32'hDEADBEEF);
        jtag_set_addr(8'h10, 1'b1);
        check("wr_rd_MonDReg", MonDReg, 32'hDEADBEEF);
        check("wr_rd_MonAReg", 32'(MonAReg), 32'h11);

        // address wrap on a read
        jtag_set_addr(8'hFF, 1'b0);
        jtag_read(1'b0);
        check("wrap_MonAReg", 32'(MonAReg), 32'h0);

        // unprivileged CPU write is dropped
        d0 = mdl_mem[3];
        cpu_write(8'd3, 32'h12345678, 4'hF, 1'b0, 1'b0);
        cpu_read(8'd3);
        check("priv_old_value", readdata, d0);

        // byte enables
        cpu_write(8'd5, 32'h0, 4'hF, 1'b1, 1'b0);
        cpu_write(8'd5, 32'hAABBCCDD, 4'b0011, 1'b1, 1'b0);
        cpu_read(8'd5);
        check("byteen_value", readdata, 32'h0000CCDD);

        // arbitration: JTAG read wins, CPU read stalls through it
        a0 = 8'($urandom_range(0, N - 1));
        mdl_d = mdl_mem[mdl_a];
        mdl_a = mdl_a + 8'd1;
        jq.push_back('{a: mdl_a, d: mdl_d});
        cq.push_back('{d: mdl_mem[a0], stall: 5});
        @(posedge clk); #1;
        address = a0; read = 1'b1; tna = 1'b1; jdo = rand_jdo();
        @(posedge clk); #1;
        tna = 1'b0;
        wait_cpu("arb_cpu_done");

        // priority: all three pulses together act as a write
        j = rand_jdo();
        a0 = mdl_a;
        mdl_mem[mdl_a] = j[34:3];
        mdl_d = j[34:3];
        mdl_a = mdl_a + 8'd1;
        jq.push_back('{a: mdl_a, d: mdl_d});
        pulse_jtag(1'b1, 1'b1, 1'b1, j);
        wait_idle("prio_done");
        cpu_read(a0);

        // pulses while busy are ignored
        jtag_read(1'b1);
        jtag_read(1'b0);

        // reset in J_RDW aborts the read
        jtag_set_addr(8'h20, 1'b0);
        @(posedge clk); #1;
        tna = 1'b1;
        @(posedge clk); #1;
        tna = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_MonDReg", MonDReg, 32'h0);
        check("rst_mid_MonAReg", 32'(MonAReg), 32'h0);
        check("rst_mid_jtag_busy", 32'(jtag_busy), 32'h0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        mdl_a = 8'h00;
        mdl_d = 32'h0;
        jtag_read(1'b0);

        // randomized mix
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 5))
                0: jtag_set_addr(8'($urandom), 1'($urandom));
                1: jtag_write($urandom);
                2: jtag_read(1'($urandom));
                3: cpu_write(8'($urandom), $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
                4: cpu_read(8'($urandom));
                default: cpu_read(mdl_a);
            endcase
        end

        repeat (3) @(negedge clk);
        check("jtag_queue_empty", 32'(jq.size()), 32'h0);
        check("cpu_queue_empty", 32'(cq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
